// File: rtl/riscv_cpu_pkg.sv
// Shared core constants and types; this slice holds the data memory responder defaults.
package riscv_cpu_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned DMEM_DEPTH    = 1024;
  localparam int unsigned DMEM_GNT_WAIT = 0;

  typedef enum logic [0:0] {
    DmemIdle,
    DmemStall
  } dmem_state_e;

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous RAM with a one-cycle registered read; contents are not reset.
module dmem_sram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data memory req/gnt/rvalid responder backed by a word-addressed RAM.
// Optional out-of-range error reporting is enabled with `define DATA_MEM_ERR_EN.
module data_mem_responder
  import riscv_cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned DEPTH      = DMEM_DEPTH,
  parameter int unsigned GNT_WAIT   = DMEM_GNT_WAIT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic [DATA_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  dmem_state_e           state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  gnt;
  logic                  addr_err;
  logic                  rvalid_q, rvalid_d;
  logic                  load_q, load_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] sram_rdata;

`ifdef DATA_MEM_ERR_EN
  // Any address bit above the word index means the word lies beyond DEPTH.
  assign addr_err = |(data_addr_i >> (AW + 2));
  logic unused_addr;
  assign unused_addr = ^data_addr_i[1:0];
`else
  assign addr_err = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{data_addr_i[DATA_WIDTH-1:AW+2], data_addr_i[1:0]};
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gnt        = 1'b0;
    unique case (state_q)
      DmemIdle: begin
        if (data_req_i) begin
          if (GNT_WAIT == 0) begin
            gnt = 1'b1;
          end else begin
            wait_cnt_d = 4'(GNT_WAIT - 1);
            state_d    = DmemStall;
          end
        end
      end
      DmemStall: begin
        if (!data_req_i) begin
          // Requester withdrew: abandon the stall without granting.
          wait_cnt_d = 4'd0;
          state_d    = DmemIdle;
        end else if (wait_cnt_q == 4'd0) begin
          gnt     = 1'b1;
          state_d = DmemIdle;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d    = DmemIdle;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    rvalid_d = gnt;
    load_d   = gnt & ~data_we_i & ~addr_err;
    err_d    = gnt & addr_err;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= DmemIdle;
      wait_cnt_q <= 4'd0;
      rvalid_q   <= 1'b0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rvalid_q   <= rvalid_d;
      load_q     <= load_d;
      err_q      <= err_d;
    end
  end

  dmem_sram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_sram (
    .clk_i  (clk_i),
    .req_i  (gnt & ~addr_err),
    .we_i   (data_we_i),
    .addr_i (data_addr_i[AW+1:2]),
    .wdata_i(data_wdata_i),
    .rdata_o(sram_rdata)
  );

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  // Stores and error loads answer with zero data.
  assign data_rdata_o  = load_q ? sram_rdata : '0;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: three responders with GNT_WAIT 0, 3 and 5 against a word-array model.
module tb_data_mem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req    [3];
  logic        we     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        err    [3];

  int checks;
  int failures;

  exp_t q0[$], q1[$], q2[$];
  logic [31:0] mdl  [3][1024];
  bit          mvld [3][1024];
  bit          gnt_prev [3];

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH(1024), .GNT_WAIT(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
    .data_rvalid_o(rvalid[0]), .data_addr_i(addr[0]), .data_we_i(we[0]),
    .data_wdata_i(wdata[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0])
  );
  data_mem_responder #(.DATA_WIDTH(32), .DEPTH(1024), .GNT_WAIT(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
    .data_rvalid_o(rvalid[1]), .data_addr_i(addr[1]), .data_we_i(we[1]),
    .data_wdata_i(wdata[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1])
  );
  data_mem_responder #(.DATA_WIDTH(32), .DEPTH(1024), .GNT_WAIT(5)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
    .data_rvalid_o(rvalid[2]), .data_addr_i(addr[2]), .data_we_i(we[2]),
    .data_wdata_i(wdata[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic int gw(input int i);
    case (i)
      0: return 0;
      1: return 3;
      default: return 5;
    endcase
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h at %0t", name, i, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop_exp(input int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Spec-level memory model: word index from the byte address, wrap or flag out-of-range.
  function automatic void model_xact(input int i, input logic w, input logic [31:0] a,
                                     input logic [31:0] d, output exp_t e);
    longint unsigned widx;
    int idx;
    bit er;
    widx = longint'(a) >> 2;
`ifdef DATA_MEM_ERR_EN
    er  = (widx >= 1024);
    idx = er ? 0 : int'(widx);
`else
    er  = 1'b0;
    idx = int'(widx % 1024);
`endif
    e.err = er;
    if (w) begin
      e.rdata = 32'h0;
      e.chk   = 1'b1;
      if (!er) begin
        mdl[i][idx]  = d;
        mvld[i][idx] = 1'b1;
      end
    end else if (er) begin
      e.rdata = 32'h0;
      e.chk   = 1'b1;
    end else begin
      e.rdata = mdl[i][idx];
      e.chk   = mvld[i][idx];
    end
  endfunction

  // Called at posedge+#1; returns at the posedge+#1 after the grant cycle.
  task automatic xact(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input bit keep);
    int   lat;
    bit   got;
    exp_t e;
    req[i]   = 1'b1;
    we[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    lat      = 0;
    got      = 1'b0;
    while (!got && lat <= 40) begin
      @(negedge clk);
      if (gnt[i]) got = 1'b1;
      else lat++;
    end
    check("gnt_latency", i, got ? 32'(lat) : 32'hFFFF_FFFF, 32'(gw(i)));
    if (got) begin
      model_xact(i, w, a, d, e);
      push_exp(i, e);
    end
    @(posedge clk);
    #1;
    if (!keep) req[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every rvalid must follow a grant by one cycle and match the queued response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 3; i++) gnt_prev[i] = 1'b0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (rvalid[i] || gnt_prev[i]) check("rvalid_after_gnt", i, 32'(rvalid[i]),
                                              32'(gnt_prev[i]));
          if (rvalid[i]) begin
            if (qsize(i) == 0) begin
              check("unexpected_rvalid", i, 32'd1, 32'd0);
            end else begin
              e = pop_exp(i);
              if (e.chk) check("rdata", i, rdata[i], e.rdata);
              check("err", i, 32'(err[i]), 32'(e.err));
            end
          end
          gnt_prev[i] = gnt[i];
        end
      end
    end
  end

  initial begin
    int hits;
    bit w;
    bit keep;
    logic [31:0] a;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_gnt", i, 32'(gnt[i]), 32'd0);
      check("reset_rvalid", i, 32'(rvalid[i]), 32'd0);
      check("reset_rdata", i, rdata[i], 32'd0);
      check("reset_err", i, 32'(err[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Store then load, zero wait states.
    xact(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
    xact(0, 1'b0, 32'h40, 32'h0, 1'b0);
    idle(2);
    // Back-to-back stores then loads with req held high.
    for (int k = 0; k < 8; k++) xact(0, 1'b1, 32'(k * 4), 32'hA000_0000 + 32'(k), 1'b1);
    for (int k = 0; k < 8; k++) xact(0, 1'b0, 32'(k * 4), 32'h0, k != 7);
    idle(2);
    // Aliasing without error reporting, error responses with it.
    xact(0, 1'b1, 32'h0, 32'h0000_AAAA, 1'b0);
    xact(0, 1'b1, 32'h1000, 32'h0000_1234, 1'b0);
    xact(0, 1'b0, 32'h1000, 32'h0, 1'b0);
    xact(0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(2);

    // Wait states: single accesses and a held request.
    xact(1, 1'b1, 32'h40, 32'h1111_2222, 1'b0);
    idle(1);
    xact(1, 1'b0, 32'h40, 32'h0, 1'b0);
    idle(1);
    for (int k = 0; k < 3; k++) xact(1, 1'b0, 32'h40, 32'h0, k != 2);
    idle(2);

    // Reset in the middle of a stall drops the request.
    xact(2, 1'b1, 32'h80, 32'h5A5A_5A5A, 1'b0);
    idle(2);
    hits     = 0;
    req[2]   = 1'b1;
    we[2]    = 1'b0;
    addr[2]  = 32'h80;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      hits += int'(gnt[2]) + int'(rvalid[2]);
      @(posedge clk);
    end
    #1;
    rst_n  = 1'b0;
    req[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      hits += int'(gnt[2]) + int'(rvalid[2]);
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      hits += int'(gnt[2]) + int'(rvalid[2]);
      @(posedge clk);
    end
    #1;
    check("reset_drop", 2, 32'(hits), 32'd0);
    xact(2, 1'b0, 32'h80, 32'h0, 1'b0);
    idle(2);

    // Randomized traffic on every instance.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 50; k++) begin
        w    = 1'($urandom_range(0, 1));
        a    = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) a = a | 32'h1000;
        keep = 1'($urandom_range(0, 1));
        xact(i, w, a, $urandom, keep);
        if (!keep) idle($urandom_range(0, 2));
      end
      req[i] = 1'b0;
      idle(2);
    end

    idle(5);
    for (int i = 0; i < 3; i++) check("queue_drained", i, 32'(qsize(i)), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
